// File: rtl/jpeg_carry_chain_pipe.sv
// jpeg_carry_chain_pipe: pipelined adder / subtractor / comparator for the JPEG
// datapath. The WIDTH-bit carry chain is cut into STAGES equal segments, one
// register stage per segment, with valid/ready elastic flow control.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_a, in_b          two's complement operands
//   in_mode             00 add, 01 sub (A-B), 10 compare, 11 treated as add
//   in_cin              carry-in, add mode only
//   out_valid/out_ready output beat handshake
//   out_sum             A+B+cin or A-B (A-B in compare mode)
//   out_cout, out_ovf   carry out of MSB, signed overflow
//   out_lt, out_eq      signed A<B and A==B, valid in every mode
module jpeg_carry_chain_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_lt,
  output logic             out_eq
);

  localparam int SEG = WIDTH / STAGES;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_CMP = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  mode_e mode;
  logic  is_sub;

  // Stage registers; index k is the output of stage k.
  logic             r_v   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_bc  [STAGES];
  logic [WIDTH-1:0] r_bn  [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c   [STAGES];
  logic             r_cd  [STAGES];
  logic             r_eq  [STAGES];
  logic             r_ovf;
  logic             r_lt;

  // Stage inputs; index k feeds stage k.
  logic             s_v   [STAGES];
  logic [WIDTH-1:0] s_a   [STAGES];
  logic [WIDTH-1:0] s_bc  [STAGES];
  logic [WIDTH-1:0] s_bn  [STAGES];
  logic [WIDTH-1:0] s_sum [STAGES];
  logic             s_c   [STAGES];
  logic             s_cd  [STAGES];
  logic             s_eq  [STAGES];

  // Per-stage resolved results.
  logic [WIDTH-1:0] n_sum [STAGES];
  logic             n_c   [STAGES];
  logic             n_cd  [STAGES];
  logic             n_eq  [STAGES];
  logic             msb_c;
  logic             msb_dc;
  logic             msb_ds;
  logic             ovf_n;
  logic             lt_n;

  logic             ready [STAGES];

  assign mode   = mode_e'(in_mode);
  assign is_sub = (mode == MODE_SUB) || (mode == MODE_CMP);

  // Stage 0 takes conditioned operands; later stages take the previous register.
  // bc is the operand for the main chain, bn (~B) feeds the parallel A-B chain.
  always_comb begin
    s_v[0]   = in_valid;
    s_a[0]   = in_a;
    s_bc[0]  = is_sub ? ~in_b : in_b;
    s_bn[0]  = ~in_b;
    s_sum[0] = '0;
    s_c[0]   = is_sub ? 1'b1 : in_cin;
    s_cd[0]  = 1'b1;
    s_eq[0]  = 1'b1;
    for (int unsigned k = 1; k < STAGES; k++) begin
      s_v[k]   = r_v[k-1];
      s_a[k]   = r_a[k-1];
      s_bc[k]  = r_bc[k-1];
      s_bn[k]  = r_bn[k-1];
      s_sum[k] = r_sum[k-1];
      s_c[k]   = r_c[k-1];
      s_cd[k]  = r_cd[k-1];
      s_eq[k]  = r_eq[k-1];
    end
  end

  // Segment carry resolution with generate/propagate, for both chains.
  always_comb begin
    logic [WIDTH-1:0] sum_t;
    logic             c_t;
    logic             cd_t;
    logic             eq_t;
    logic             g;
    logic             p;
    logic             pd;
    int unsigned      i;
    msb_c  = 1'b0;
    msb_dc = 1'b0;
    msb_ds = 1'b0;
    sum_t  = '0;
    c_t    = 1'b0;
    cd_t   = 1'b0;
    eq_t   = 1'b0;
    g      = 1'b0;
    p      = 1'b0;
    pd     = 1'b0;
    i      = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum_t = s_sum[k];
      c_t   = s_c[k];
      cd_t  = s_cd[k];
      eq_t  = s_eq[k];
      for (int unsigned j = 0; j < SEG; j++) begin
        i  = k * SEG + j;
        g  = s_a[k][i] & s_bc[k][i];
        p  = s_a[k][i] ^ s_bc[k][i];
        pd = s_a[k][i] ^ s_bn[k][i];
        if (i == WIDTH - 1) begin
          msb_c  = c_t;
          msb_dc = cd_t;
          msb_ds = pd ^ cd_t;
        end
        sum_t[i] = p ^ c_t;
        c_t      = g | (p & c_t);
        cd_t     = (s_a[k][i] & s_bn[k][i]) | (pd & cd_t);
        // a ^ ~b is the XNOR of a and b
        eq_t     = eq_t & pd;
      end
      n_sum[k] = sum_t;
      n_c[k]   = c_t;
      n_cd[k]  = cd_t;
      n_eq[k]  = eq_t;
    end
  end

  assign ovf_n = msb_c ^ n_c[STAGES-1];
  assign lt_n  = msb_ds ^ (msb_dc ^ n_cd[STAGES-1]);

  // Ready ripples back from the output through a running variable so the
  // array itself is never read inside this block.
  always_comb begin
    logic        rdy;
    int unsigned idx;
    rdy = out_ready;
    idx = 0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      idx        = STAGES - 1 - j;
      rdy        = !r_v[idx] || rdy;
      ready[idx] = rdy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_v[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_bc[k]  <= '0;
        r_bn[k]  <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_cd[k]  <= 1'b0;
        r_eq[k]  <= 1'b0;
      end
      r_ovf <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          r_v[k]   <= s_v[k];
          r_a[k]   <= s_a[k];
          r_bc[k]  <= s_bc[k];
          r_bn[k]  <= s_bn[k];
          r_sum[k] <= n_sum[k];
          r_c[k]   <= n_c[k];
          r_cd[k]  <= n_cd[k];
          r_eq[k]  <= n_eq[k];
        end
      end
      if (ready[STAGES-1]) begin
        r_ovf <= ovf_n;
        r_lt  <= lt_n;
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = r_v[STAGES-1];
  assign out_sum   = r_sum[STAGES-1];
  assign out_cout  = r_c[STAGES-1];
  assign out_ovf   = r_ovf;
  assign out_lt    = r_lt;
  assign out_eq    = r_eq[STAGES-1];

endmodule

// File: tb/tb_jpeg_carry_chain_pipe.sv
// Bench for jpeg_carry_chain_pipe (WIDTH=16, STAGES=2): directed vectors,
// backpressure, mid-stream reset and a random stream, all scored against a
// reference model through an expected-result queue.
module tb_jpeg_carry_chain_pipe;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_mode;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_lt;
  logic          out_eq;

  int unsigned   total;
  int unsigned   bad;
  int unsigned   acc_cnt;
  logic [W+3:0]  exp_q [$];
  logic [W+3:0]  head;
  logic [W-1:0]  held;
  logic          drv_done;

  jpeg_carry_chain_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_lt    (out_lt),
    .out_eq    (out_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {sum, cout, ovf, lt, eq}
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] m, input logic cin);
    logic [W:0] f;
    logic       sub;
    logic       ovf;
    sub = (m == 2'b01) || (m == 2'b10);
    if (sub) begin
      f   = {1'b0, a} + {1'b0, ~b} + 17'd1;
      ovf = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
    end else begin
      f   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      ovf = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
    end
    return {f[W-1:0], f[W], ovf, ($signed(a) < $signed(b)), (a == b)};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          head = exp_q.pop_front();
          check("out", {out_sum, out_cout, out_ovf, out_lt, out_eq}, head);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_mode, in_cin));
        acc_cnt++;
      end
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] m, input logic c);
    logic ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_cin   = c;
    in_valid = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("in_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] m, input logic c, input logic [W+3:0] exp);
    drive_beat(a, b, m, c);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_lat2"}, out_valid, 1'b1);
    check({tag, "_res"}, {out_sum, out_cout, out_ovf, out_lt, out_eq}, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    acc_cnt   = 0;
    drv_done  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 2'b00;
    in_cin    = 1'b0;
    out_ready = 1'b1;

    #3;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum", out_sum, 16'h0000);
    check("rst_flags", {out_cout, out_ovf, out_lt, out_eq}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", in_ready, 1'b1);

    // Directed vectors: {sum, cout, ovf, lt, eq}
    run_dir("add_ovf", 16'h7FFF, 16'h0001, 2'b00, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    run_dir("sub_neg", 16'h0003, 16'h0005, 2'b01, 1'b0, {16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0});
    run_dir("cmp_eq",  16'h1234, 16'h1234, 2'b10, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    run_dir("ripple",  16'hFFFF, 16'h0000, 2'b00, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    run_dir("rsv_add", 16'h8000, 16'h8000, 2'b11, 1'b1, {16'h0001, 1'b1, 1'b1, 1'b0, 1'b1});
    run_dir("sub_cin", 16'h8000, 16'h0001, 2'b01, 1'b0, {16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0});
    drain("drain_dir");

    // Backpressure: only STAGES beats fit, the head is held unchanged.
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive_beat(16'h1000 + 16'(i * 16'h0111), 16'h0100 + 16'(i), 2'(i % 3), 1'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", acc_cnt, 2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        held = out_sum;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold", out_sum, held);
        check("bp_accepted2", acc_cnt, 2);
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_total", acc_cnt, 6);

    // Reset with two beats in flight.
    drive_beat(16'h00AA, 16'h0055, 2'b00, 1'b0);
    drive_beat(16'h0F0F, 16'h0101, 2'b01, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", out_sum, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_dir("post_rst", 16'h0002, 16'h0003, 2'b00, 1'b1, {16'h0006, 1'b0, 1'b0, 1'b1, 1'b0});
    drain("drain_rst");

    // Random stream with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          drive_beat(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
